// File: rtl/axi_4_pkg.sv
// Shared AXI4 definitions for the master and slave controllers.
//   axi_4_master_states_e : burst sequencer states of the VLSU-facing master
//   axi_4_slave_states_e  : states of the companion slave controller
//   rlast_mismatch()      : flags disagreement between s_rlast and the beat count
package axi_4_pkg;

    typedef enum logic [2:0] {
        M_IDLE    = 3'd0,
        M_RD_ADDR = 3'd1,
        M_RD_DATA = 3'd2,
        M_WR      = 3'd3,
        M_WR_RESP = 3'd4
    } axi_4_master_states_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD      = 2'd1,
        S_WR      = 2'd2,
        S_WR_RESP = 2'd3
    } axi_4_slave_states_e;

    // High when the slave's last-beat marker and our own beat count disagree.
    function automatic logic rlast_mismatch(input logic rlast, input logic is_last);
        return rlast ^ is_last;
    endfunction

endpackage

// File: rtl/axi_4_beat_counter.sv
// Beat counter for AXI4 bursts.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   clear            : return the beat index to 0 (wins over inc)
//   load, load_len   : latch the burst length (beats minus one)
//   inc              : advance one beat; saturates at the latched length
//   idx              : current beat index
//   is_last          : idx equals the latched length
module axi_4_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [LEN_W-1:0] load_len,
    input  logic             inc,
    output logic [LEN_W-1:0] idx,
    output logic             is_last
);

    logic [LEN_W-1:0] idx_r;
    logic [LEN_W-1:0] len_r;

    // Burst length latch and saturating beat index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r <= {LEN_W{1'b0}};
            len_r <= {LEN_W{1'b0}};
        end else begin
            if (load) begin
                len_r <= load_len;
            end else begin
                len_r <= len_r;
            end
            if (clear) begin
                idx_r <= {LEN_W{1'b0}};
            end else if (inc && (idx_r != len_r)) begin
                idx_r <= idx_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign idx     = idx_r;
    assign is_last = (idx_r == len_r);

endmodule

// File: rtl/axi_4_master_controller.sv
// AXI4 burst master sequencing VLSU load/store requests onto AR/R and AW/W/B.
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   ld_req, st_req, burst_len     : VLSU requests (load has priority), beats minus one
//   m_arvalid/s_arready           : read address channel
//   s_rvalid/s_rlast/m_rready     : read data channel
//   m_awvalid/s_awready           : write address channel
//   m_wvalid/s_wready/m_wlast     : write data channel
//   s_bvalid/m_bready             : write response channel
//   beat_idx                      : current beat for VLSU data select
//   rd_beat, wr_beat              : pulse on each R / W handshake
//   ld_done, st_done              : completion pulse, cycle after the final handshake
//   rlast_err                     : s_rlast disagreed with the beat count
//   busy                          : controller not idle
module axi_4_master_controller
    import axi_4_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_req,
    input  logic             st_req,
    input  logic [LEN_W-1:0] burst_len,
    output logic             m_arvalid,
    input  logic             s_arready,
    input  logic             s_rvalid,
    input  logic             s_rlast,
    output logic             m_rready,
    output logic             m_awvalid,
    input  logic             s_awready,
    output logic             m_wvalid,
    input  logic             s_wready,
    output logic             m_wlast,
    input  logic             s_bvalid,
    output logic             m_bready,
    output logic [LEN_W-1:0] beat_idx,
    output logic             rd_beat,
    output logic             wr_beat,
    output logic             ld_done,
    output logic             st_done,
    output logic             rlast_err,
    output logic             busy
);

    axi_4_master_states_e state_r, next_state_s;

    logic aw_done_r, w_done_r;
    logic ld_done_r, st_done_r;
    logic aw_done_set_s, w_done_set_s;
    logic ld_done_set_s, st_done_set_s;
    logic cnt_clear_s, cnt_inc_s, len_load_s, cnt_last_s;

    axi_4_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .load     (len_load_s),
        .load_len (burst_len),
        .inc      (cnt_inc_s),
        .idx      (beat_idx),
        .is_last  (cnt_last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= M_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Write-channel progress flags; only meaningful while in M_WR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (state_r == M_WR) begin
            aw_done_r <= aw_done_r | aw_done_set_s;
            w_done_r  <= w_done_r | w_done_set_s;
        end else begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end
    end

    // Completion pulses, delayed one cycle after the terminating handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_done_r <= 1'b0;
            st_done_r <= 1'b0;
        end else begin
            ld_done_r <= ld_done_set_s;
            st_done_r <= st_done_set_s;
        end
    end

    // Next-state and channel control decode.
    always_comb begin
        next_state_s  = state_r;
        m_arvalid     = 1'b0;
        m_rready      = 1'b0;
        m_awvalid     = 1'b0;
        m_wvalid      = 1'b0;
        m_wlast       = 1'b0;
        m_bready      = 1'b0;
        rd_beat       = 1'b0;
        wr_beat       = 1'b0;
        rlast_err     = 1'b0;
        cnt_clear_s   = 1'b0;
        cnt_inc_s     = 1'b0;
        len_load_s    = 1'b0;
        aw_done_set_s = 1'b0;
        w_done_set_s  = 1'b0;
        ld_done_set_s = 1'b0;
        st_done_set_s = 1'b0;
        case (state_r)
            M_IDLE: begin
                cnt_clear_s = 1'b1;
                if (ld_req) begin
                    len_load_s   = 1'b1;
                    next_state_s = M_RD_ADDR;
                end else if (st_req) begin
                    len_load_s   = 1'b1;
                    next_state_s = M_WR;
                end else begin
                    next_state_s = M_IDLE;
                end
            end
            M_RD_ADDR: begin
                m_arvalid = 1'b1;
                if (s_arready) begin
                    next_state_s = M_RD_DATA;
                end else begin
                    next_state_s = M_RD_ADDR;
                end
            end
            M_RD_DATA: begin
                m_rready = 1'b1;
                if (s_rvalid) begin
                    rd_beat   = 1'b1;
                    rlast_err = rlast_mismatch(s_rlast, cnt_last_s);
                    // The slave's rlast ends the burst even if the count disagrees.
                    if (s_rlast) begin
                        cnt_clear_s   = 1'b1;
                        ld_done_set_s = 1'b1;
                        next_state_s  = M_IDLE;
                    end else begin
                        cnt_inc_s    = 1'b1;
                        next_state_s = M_RD_DATA;
                    end
                end else begin
                    next_state_s = M_RD_DATA;
                end
            end
            M_WR: begin
                m_awvalid     = ~aw_done_r;
                m_wvalid      = ~w_done_r;
                m_wlast       = ~w_done_r & cnt_last_s;
                aw_done_set_s = ~aw_done_r & s_awready;
                if (!w_done_r && s_wready) begin
                    wr_beat      = 1'b1;
                    cnt_inc_s    = 1'b1;
                    w_done_set_s = cnt_last_s;
                end else begin
                    w_done_set_s = 1'b0;
                end
                // AW and the last W may finish in either order or together.
                if ((aw_done_r || aw_done_set_s) && (w_done_r || w_done_set_s)) begin
                    next_state_s = M_WR_RESP;
                end else begin
                    next_state_s = M_WR;
                end
            end
            M_WR_RESP: begin
                m_bready = 1'b1;
                if (s_bvalid) begin
                    cnt_clear_s   = 1'b1;
                    st_done_set_s = 1'b1;
                    next_state_s  = M_IDLE;
                end else begin
                    next_state_s = M_WR_RESP;
                end
            end
            default: begin
                next_state_s = M_IDLE;
            end
        endcase
    end

    assign ld_done = ld_done_r;
    assign st_done = st_done_r;
    assign busy    = (state_r != M_IDLE);

endmodule

// File: tb/tb_axi_4_master_controller.sv
// Self-checking bench for axi_4_master_controller. The bench plays the AXI
// slave and the VLSU; expected behaviour is derived per transaction from beat
// counts, handshake bookkeeping and min(k,len) saturation arithmetic.
module tb_axi_4_master_controller;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             ld_req, st_req;
    logic [LEN_W-1:0] burst_len;
    logic             m_arvalid, s_arready;
    logic             s_rvalid, s_rlast, m_rready;
    logic             m_awvalid, s_awready;
    logic             m_wvalid, s_wready, m_wlast;
    logic             s_bvalid, m_bready;
    logic [LEN_W-1:0] beat_idx;
    logic             rd_beat, wr_beat, ld_done, st_done, rlast_err, busy;

    int checks   = 0;
    int failures = 0;

    axi_4_master_controller #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .st_req    (st_req),
        .burst_len (burst_len),
        .m_arvalid (m_arvalid),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rlast   (s_rlast),
        .m_rready  (m_rready),
        .m_awvalid (m_awvalid),
        .s_awready (s_awready),
        .m_wvalid  (m_wvalid),
        .s_wready  (s_wready),
        .m_wlast   (m_wlast),
        .s_bvalid  (s_bvalid),
        .m_bready  (m_bready),
        .beat_idx  (beat_idx),
        .rd_beat   (rd_beat),
        .wr_beat   (wr_beat),
        .ld_done   (ld_done),
        .st_done   (st_done),
        .rlast_err (rlast_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        ld_req = 1'b0; st_req = 1'b0; burst_len = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        idle_inputs();
        reset = 1'b0;
        #12;
        // Aggressive inputs during reset must not leak to outputs.
        ld_req = 1'b1; s_rvalid = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        #3;
        outs = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready,
                rd_beat, wr_beat, ld_done, st_done, rlast_err, busy};
        checks++;
        if (outs !== 12'b0 || beat_idx !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got outs=%b beat_idx=%0d required all 0", outs, beat_idx);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, m_arvalid, m_awvalid, m_wvalid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy/ar/aw/w=%b required 0000",
                     {busy, m_arvalid, m_awvalid, m_wvalid});
        end
    endtask

    task automatic issue(input logic ld, input logic st, input int len, input logic hold_st);
        @(negedge clk);
        ld_req = ld; st_req = st; burst_len = len[LEN_W-1:0];
        #1;
        checks++;
        if ({busy, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 6'b0) begin
            failures++;
            $display("FAIL issue_idle: got busy/valids=%b required 000000",
                     {busy, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
        if (!hold_st) st_req = 1'b0;
    endtask

    task automatic load_addr_phase(input int delay);
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            s_arready = (c == delay);
            #1;
            checks++;
            if ({busy, m_arvalid, m_rready, rd_beat} !== 4'b1100) begin
                failures++;
                $display("FAIL rd_addr: got busy/arvalid/rready/rd_beat=%b required 1100",
                         {busy, m_arvalid, m_rready, rd_beat});
            end
        end
    endtask

    task automatic load_data_phase(input int len, input int rlast_beat, input logic all_valid);
        int k = 0;
        int guard = 0;
        int exp_idx;
        logic v, exp_err;
        while (k <= rlast_beat && guard < 500) begin
            @(negedge clk);
            guard++;
            s_arready = 1'b0;
            v = all_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            s_rvalid = v;
            s_rlast  = v && (k == rlast_beat);
            exp_idx  = (k < len) ? k : len;
            exp_err  = v && ((k == rlast_beat) != (exp_idx == len));
            #1;
            checks++;
            if ({busy, m_arvalid, m_rready, rd_beat, rlast_err, ld_done} !==
                {1'b1, 1'b0, 1'b1, v, exp_err, 1'b0}) begin
                failures++;
                $display("FAIL rd_data beat %0d: got busy/ar/rready/rd_beat/rlast_err/ld_done=%b required %b",
                         k, {busy, m_arvalid, m_rready, rd_beat, rlast_err, ld_done},
                         {1'b1, 1'b0, 1'b1, v, exp_err, 1'b0});
            end
            checks++;
            if (beat_idx !== exp_idx[LEN_W-1:0]) begin
                failures++;
                $display("FAIL rd_beat_idx beat %0d: got %0d required %0d", k, beat_idx, exp_idx);
            end
            if (v) k++;
        end
        if (guard >= 500) begin
            checks++; failures++;
            $display("FAIL rd_data_timeout: got %0d beats required %0d", k, rlast_beat + 1);
        end
    endtask

    task automatic check_ld_done();
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++;
        if ({ld_done, busy, rd_beat, m_rready} !== 4'b1000 || beat_idx !== '0) begin
            failures++;
            $display("FAIL ld_done: got ld_done/busy/rd_beat/rready=%b beat_idx=%0d required 1000 idx 0",
                     {ld_done, busy, rd_beat, m_rready}, beat_idx);
        end
        @(posedge clk); #1;
        st_req = 1'b0;
        checks++;
        if (ld_done !== 1'b0) begin
            failures++;
            $display("FAIL ld_done_width: got %b required 0", ld_done);
        end
    endtask

    task automatic store_data_phase(input int len, input int aw_delay, input int w_stall,
                                    input logic w_random);
        int wcnt = 0;
        int cyc = 0;
        logic awd = 1'b0;
        logic ea, ew, ewl, ar, wr;
        logic [LEN_W-1:0] widx;
        while (!(awd && wcnt > len) && cyc < 500) begin
            @(negedge clk);
            ea  = !awd;
            ew  = (wcnt <= len);
            ewl = ew && (wcnt == len);
            ar  = (cyc >= aw_delay);
            wr  = (cyc < w_stall) ? 1'b0 : (w_random ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_awready = ar; s_wready = wr;
            widx = wcnt[LEN_W-1:0];
            #1;
            checks++;
            if ({busy, m_awvalid, m_wvalid, m_wlast, m_bready, wr_beat, st_done} !==
                {1'b1, ea, ew, ewl, 1'b0, ew && wr, 1'b0}) begin
                failures++;
                $display("FAIL wr cycle %0d: got busy/aw/w/wlast/bready/wr_beat/st_done=%b required %b",
                         cyc, {busy, m_awvalid, m_wvalid, m_wlast, m_bready, wr_beat, st_done},
                         {1'b1, ea, ew, ewl, 1'b0, ew && wr, 1'b0});
            end
            if (ew) begin
                checks++;
                if (beat_idx !== widx) begin
                    failures++;
                    $display("FAIL wr_beat_idx: got %0d required %0d", beat_idx, wcnt);
                end
            end
            if (ea && ar) awd = 1'b1;
            if (ew && wr) wcnt++;
            cyc++;
        end
        if (cyc >= 500) begin
            checks++; failures++;
            $display("FAIL wr_timeout: got %0d beats aw=%b required %0d beats aw=1", wcnt, awd, len + 1);
        end
    endtask

    task automatic store_resp_phase(input int b_delay);
        for (int c = 0; c <= b_delay; c++) begin
            @(negedge clk);
            s_awready = 1'b0; s_wready = 1'b0;
            s_bvalid = (c == b_delay);
            #1;
            checks++;
            if ({busy, m_bready, m_awvalid, m_wvalid, st_done} !== 5'b11000) begin
                failures++;
                $display("FAIL wr_resp: got busy/bready/aw/w/st_done=%b required 11000",
                         {busy, m_bready, m_awvalid, m_wvalid, st_done});
            end
        end
        @(negedge clk);
        s_bvalid = 1'b0;
        #1;
        checks++;
        if ({st_done, busy, m_bready} !== 3'b100 || beat_idx !== '0) begin
            failures++;
            $display("FAIL st_done: got st_done/busy/bready=%b beat_idx=%0d required 100 idx 0",
                     {st_done, busy, m_bready}, beat_idx);
        end
        @(posedge clk); #1;
        checks++;
        if (st_done !== 1'b0) begin
            failures++;
            $display("FAIL st_done_width: got %b required 0", st_done);
        end
    endtask

    task automatic test_load_basic();
        issue(1'b1, 1'b0, 3, 1'b0);
        load_addr_phase(0);
        load_data_phase(3, 3, 1'b1);
        check_ld_done();
    endtask

    task automatic test_store_aw_delay();
        issue(1'b0, 1'b1, 2, 1'b0);
        store_data_phase(2, 5, 0, 1'b0);
        store_resp_phase(2);
    endtask

    task automatic test_store_len0_wstall();
        issue(1'b0, 1'b1, 0, 1'b0);
        store_data_phase(0, 0, 3, 1'b0);
        store_resp_phase(3);
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b1, 1, 1'b1);
        load_addr_phase(1);
        load_data_phase(1, 1, 1'b1);
        check_ld_done();
        store_data_phase(1, 0, 0, 1'b0);
        store_resp_phase(0);
    endtask

    task automatic test_rlast_err();
        issue(1'b1, 1'b0, 3, 1'b0);
        load_addr_phase(0);
        load_data_phase(3, 1, 1'b1);
        check_ld_done();
        // Late rlast: beat_idx saturates at len while extra beats flag errors.
        issue(1'b1, 1'b0, 3, 1'b0);
        load_addr_phase(0);
        load_data_phase(3, 5, 1'b1);
        check_ld_done();
    endtask

    task automatic test_reset_mid_burst();
        logic [11:0] outs;
        logic [LEN_W-1:0] eidx;
        issue(1'b0, 1'b1, 7, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_wready = 1'b1; s_awready = 1'b0;
            eidx = c[LEN_W-1:0];
            #1;
            checks++;
            if (beat_idx !== eidx || m_wvalid !== 1'b1) begin
                failures++;
                $display("FAIL pre_reset_beat: got idx=%0d wvalid=%b required idx=%0d wvalid=1",
                         beat_idx, m_wvalid, c);
            end
        end
        #1;
        reset = 1'b0;
        #1;
        outs = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready,
                rd_beat, wr_beat, ld_done, st_done, rlast_err, busy};
        checks++;
        if (outs !== 12'b0 || beat_idx !== '0) begin
            failures++;
            $display("FAIL async_abort: got outs=%b beat_idx=%0d required all 0", outs, beat_idx);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (st_done !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_st_done: got %b required 0", st_done);
            end
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, st_done, m_wvalid} !== 3'b000) begin
            failures++;
            $display("FAIL restart_idle: got busy/st_done/wvalid=%b required 000",
                     {busy, st_done, m_wvalid});
        end
        issue(1'b1, 1'b0, 2, 1'b0);
        load_addr_phase(1);
        load_data_phase(2, 2, 1'b0);
        check_ld_done();
    endtask

    task automatic test_random();
        int len, d1, d2, d3;
        for (int t = 0; t < 10; t++) begin
            len = $urandom_range(0, 7);
            d1  = $urandom_range(0, 3);
            d2  = $urandom_range(0, 3);
            d3  = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                issue(1'b1, 1'b0, len, 1'b0);
                load_addr_phase(d1);
                load_data_phase(len, len, 1'b0);
                check_ld_done();
            end else begin
                issue(1'b0, 1'b1, len, 1'b0);
                store_data_phase(len, d1, d2, 1'b1);
                store_resp_phase(d3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_aw_delay();
        test_store_len0_wstall();
        test_back_to_back();
        test_rlast_err();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_4_master_controller.md
AXI_4_MASTER_CONTROLLER -- requirements
Module: axi_4_master_controller

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the burst length field (AXI4 AxLEN, beats minus one).
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ld_req  input  1  VLSU load request, level.
REQ-005 SHALL have port st_req  input  1  VLSU store request, level.
REQ-006 SHALL have port burst_len  input  LEN_W  beats minus one, sampled on request acceptance.
REQ-007 SHALL have port m_arvalid  output  1  read address valid.
REQ-008 SHALL have port s_arready  input  1  read address ready.
REQ-009 SHALL have port s_rvalid  input  1  read data valid.
REQ-010 SHALL have port s_rlast  input  1  last read beat.
REQ-011 SHALL have port m_rready  output  1  read data ready.
REQ-012 SHALL have port m_awvalid  output  1  write address valid.
REQ-013 SHALL have port s_awready  input  1  write address ready.
REQ-014 SHALL have port m_wvalid  output  1  write data valid.
REQ-015 SHALL have port s_wready  input  1  write data ready.
REQ-016 SHALL have port m_wlast  output  1  last write beat.
REQ-017 SHALL have port s_bvalid  input  1  write response valid.
REQ-018 SHALL have port m_bready  output  1  write response ready.
REQ-019 SHALL have port beat_idx  output  LEN_W  index of the current beat, for VLSU data select.
REQ-020 SHALL have port rd_beat / wr_beat  output  1 each  one-cycle pulse per accepted R / W handshake.
REQ-021 SHALL have port ld_done / st_done  output  1 each  one-cycle completion pulse.
REQ-022 SHALL have port rlast_err  output  1  one-cycle pulse when s_rlast disagrees with beat count.
REQ-023 SHALL have port busy  output  1  high whenever the state is not M_IDLE.

Function
REQ-024 SHALL implement states M_IDLE, M_RD_ADDR, M_RD_DATA, M_WR, M_WR_RESP.
REQ-025 M_IDLE: ld_req SHALL win over st_req when both are high; burst_len latched, beat_idx cleared; ld_req -> M_RD_ADDR, st_req -> M_WR.
REQ-026 Every valid SHALL assert independently of ready and hold stable until its handshake (valid && ready on the same rising edge).
REQ-027 M_RD_ADDR: m_arvalid=1; AR handshake -> M_RD_DATA.
REQ-028 M_RD_DATA: m_rready=1; each R handshake pulses rd_beat and increments beat_idx; R handshake with s_rlast -> M_IDLE with ld_done pulse in the following cycle.
REQ-029 rlast_err SHALL pulse on an R handshake where s_rlast=1 and beat_idx!=len, or s_rlast=0 and beat_idx==len; the transfer still terminates only on s_rlast.
REQ-030 M_WR: m_awvalid SHALL stay high until the AW handshake, then latch an aw_done flag; m_wvalid SHALL stay high from entry; the two channels are independent and either may complete first.
REQ-031 m_wlast SHALL equal (beat_idx==len) while m_wvalid=1; each W handshake pulses wr_beat and increments beat_idx.
REQ-032 M_WR -> M_WR_RESP only when the last W handshake and the AW handshake have both occurred (same cycle allowed).
REQ-033 M_WR_RESP: m_bready=1; B handshake -> M_IDLE with st_done pulse in the following cycle.
REQ-034 beat_idx SHALL saturate at len and never wrap; len=0 is a single-beat burst with m_wlast=1 on the first beat.
REQ-035 Request inputs SHALL be ignored outside M_IDLE; back-to-back requests SHALL cost exactly one M_IDLE cycle.

Reset
REQ-036 While reset=0: state M_IDLE, all valid/ready/pulse outputs 0, beat_idx 0, aw_done 0, latched len 0.
REQ-037 Reset assertion mid-burst SHALL abort immediately with no completion pulse; deassertion SHALL resume in M_IDLE.

Structure
REQ-038 axi_4_master_states_e SHALL be declared in axi_4_pkg next to the slave state enum.
REQ-039 The beat counter (clear, increment, saturate, last compare) SHALL be the sub-module axi_4_beat_counter.

Verification
REQ-040 Load, len=3, slave ready at once: arvalid 1 cycle, 4 rd_beat pulses with beat_idx 0..3, ld_done 1 cycle after rlast.
REQ-041 Store, len=2, awready delayed 5 cycles, wready always high: 3 wr_beat pulses, wlast on beat 2, M_WR_RESP only after AW, st_done after B.
REQ-042 Store, len=0, wready low 3 cycles: wvalid and wlast held stable throughout; single beat; bready until bvalid.
REQ-043 ld_req and st_req together in M_IDLE: read runs first; store starts after exactly one M_IDLE cycle.
REQ-044 Load len=3 with s_rlast on beat 1: rlast_err pulses, ld_done follows, beat_idx back to 0.
REQ-045 Reset asserted at beat 2 of a len=7 store: all outputs 0 asynchronously, no st_done, clean restart.
